// File: rtl/avg_fb_pkg.sv
// rtl/avg_fb_pkg.sv - shared states, frame constants and checksum for the averaging feedback path
package avg_fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WINDOW = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SEND   = 3'd3,
    ST_CLEAR  = 3'd4
  } fb_state_t;

  localparam logic [7:0] HDR_DEF     = 8'hA5;
  localparam int         FRAME_BYTES = 4;

  function automatic logic [7:0] fb_csum(input logic [7:0] hdr, input logic [15:0] val);
    return hdr ^ val[15:8] ^ val[7:0];
  endfunction

endpackage

// File: rtl/fb_byte_tx.sv
// rtl/fb_byte_tx.sv - 4-byte frame sequencer with a registered valid/ready byte output
module fb_byte_tx
  import avg_fb_pkg::*;
#(
  parameter logic [7:0] HDR = HDR_DEF
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] val,
  input  logic [7:0]  csum,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done
);

  localparam int IW = $clog2(FRAME_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [15:0]   val_q;
  logic [7:0]    csum_q;
  logic [7:0]    byte_nxt;

  assign idx_nxt = idx + IW'(1);
  assign done    = tx_valid && tx_ready && (idx == LAST_IDX);

  always_comb begin
    byte_nxt = csum_q;
    case (idx_nxt)
      IW'(0):  byte_nxt = HDR;
      IW'(1):  byte_nxt = val_q[15:8];
      IW'(2):  byte_nxt = val_q[7:0];
      default: byte_nxt = csum_q;
    endcase
  end

  // tx_data only moves on load or on an accepted byte, so it is stable while stalled
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      val_q    <= '0;
      csum_q   <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      idx      <= '0;
      val_q    <= val;
      csum_q   <= csum;
      tx_valid <= 1'b1;
      tx_data  <= HDR;
    end else if (tx_valid && tx_ready) begin
      if (idx == LAST_IDX) begin
        tx_valid <= 1'b0;
        tx_data  <= '0;
      end else begin
        idx     <= idx_nxt;
        tx_data <= byte_nxt;
      end
    end
  end

endmodule

// File: rtl/avg_feedback_tx.sv
// rtl/avg_feedback_tx.sv - windowed averager consumer: latch avg_vol, send frame, clear accumulator
module avg_feedback_tx
  import avg_fb_pkg::*;
#(
  parameter int unsigned WIN_CYCLES = 100000,
  parameter int unsigned DIV_LAT    = 34,
  parameter int unsigned CLR_CYCLES = 4,
  parameter logic [7:0]  HDR        = HDR_DEF
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        force_req,
  input  logic [15:0] avg_vol,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        feedback_finish,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam logic [31:0] WIN_LAST = 32'(WIN_CYCLES - 1);
  localparam logic [31:0] DIV_LAST = 32'(DIV_LAT - 1);
  localparam logic [31:0] CLR_LAST = 32'(CLR_CYCLES - 1);

  fb_state_t   state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [15:0] fcnt_nxt;
  logic        busy_nxt;
  logic        load;
  logic        done;

  // Reset parks in CLEAR so the accumulator is wiped on the way out of reset
  assign feedback_finish = (state == ST_CLEAR);

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      cnt       <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame_cnt <= fcnt_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 32'd1;
    fcnt_nxt  = frame_cnt;
    load      = 1'b0;
    case (state)
      ST_CLEAR: begin
        if (cnt == CLR_LAST) begin
          cnt_nxt   = '0;
          state_nxt = enable ? ST_WINDOW : ST_IDLE;
        end
      end
      ST_IDLE: begin
        cnt_nxt = '0;
        if (enable) state_nxt = ST_WINDOW;
      end
      ST_WINDOW: begin
        if (force_req || cnt == WIN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt   = '0;
          load      = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        cnt_nxt = '0;
        if (done) begin
          fcnt_nxt  = frame_cnt + 16'd1;
          state_nxt = ST_CLEAR;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_CLEAR;
      end
    endcase
    busy_nxt = !(state_nxt == ST_IDLE || state_nxt == ST_WINDOW);
  end

  fb_byte_tx #(.HDR(HDR)) u_byte_tx (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .load     (load),
    .val      (avg_vol),
    .csum     (fb_csum(HDR, avg_vol)),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .done     (done)
  );

endmodule

// File: tb/tb_avg_feedback_tx.sv
// tb/tb_avg_feedback_tx.sv - randomized self-checking bench for avg_feedback_tx
module tb_avg_feedback_tx;

  localparam int WIN = 16;
  localparam int DIV = 4;
  localparam int CLR = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        force_req;
  logic [15:0] avg_vol;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        feedback_finish;
  logic        busy;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;
  logic [7:0] got [4];

  avg_feedback_tx #(
    .WIN_CYCLES (WIN),
    .DIV_LAT    (DIV),
    .CLR_CYCLES (CLR),
    .HDR        (8'hA5)
  ) dut (
    .clk_100M        (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .force_req       (force_req),
    .avg_vol         (avg_vol),
    .tx_ready        (tx_ready),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .feedback_finish (feedback_finish),
    .busy            (busy),
    .frame_cnt       (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] model_byte(input logic [15:0] v, input int i);
    logic [7:0] f [4];
    f[0] = 8'hA5;
    f[1] = v[15:8];
    f[2] = v[7:0];
    f[3] = f[0] ^ f[1] ^ f[2];
    return f[i];
  endfunction

  // Counts consecutive negedges where: which=0 feedback_finish high, which=1 window/settle (no ff, no valid)
  task automatic run_len(input int which, output int n);
    n = 0;
    while (n < 200 && ((which == 0) ? (feedback_finish === 1'b1)
                                    : (feedback_finish === 1'b0 && tx_valid === 1'b0))) begin
      @(negedge clk);
      n++;
    end
  endtask

  // flags bit0: random force_req during SEND; bit1: drop enable at first valid
  task automatic collect_frame(input int mode, input int flags, input logic [15:0] vol_after,
                               output int nbytes, output int stall_err, output int first_wait,
                               output int cyc);
    int k;
    logic hold;
    logic [7:0] prev;
    nbytes = 0; stall_err = 0; first_wait = -1; cyc = 0; k = 0; hold = 1'b0; prev = 8'h00;
    while (nbytes < 4 && cyc < 400) begin
      if (hold && (tx_valid !== 1'b1 || tx_data !== prev)) stall_err++;
      if (tx_valid === 1'b1) begin
        if (first_wait < 0) begin
          first_wait = cyc;
          avg_vol = vol_after;
          if (flags[1]) enable = 1'b0;
        end
        force_req = flags[0] ? 1'($urandom_range(0, 1)) : 1'b0;
        case (mode)
          0:       tx_ready = 1'b1;
          1:       tx_ready = (k % 3 == 0);
          default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        k++;
        if (tx_ready) begin
          got[nbytes] = tx_data;
          nbytes++;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          prev = tx_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    force_req = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset;
    int n, nb, se, fw, cy;
    rst_n = 1'b0; enable = 1'b1; force_req = 1'b0; tx_ready = 1'b1; avg_vol = 16'h1234;
    repeat (2) @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    total++; if (feedback_finish !== 1'b1) begin bad++; $display("FAIL rst_ff got %b want 1", feedback_finish); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    run_len(0, n);
    total++; if (n != CLR) begin bad++; $display("FAIL first_clear_len got %0d want %0d", n, CLR); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL window_busy got %b want 0", busy); end
    run_len(1, n);
    total++; if (n != WIN + DIV) begin bad++; $display("FAIL window_settle_len got %0d want %0d", n, WIN + DIV); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL send_busy got %b want 1", busy); end
    collect_frame(0, 0, avg_vol, nb, se, fw, cy);
    exp_frames++;
    total++; if (nb != 4 || cy - fw != 4) begin bad++; $display("FAIL b2b_bytes got n=%0d cycles=%0d want 4 in 4", nb, cy - fw); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== model_byte(16'h1234, i)) begin
        bad++; $display("FAIL first_frame_byte%0d got %h want %h", i, got[i], model_byte(16'h1234, i));
      end
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL valid_after_frame got %b want 0", tx_valid); end
    total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL frame_cnt1 got %0d want %0d", frame_cnt, exp_frames); end
    run_len(0, n);
    total++; if (n != CLR) begin bad++; $display("FAIL clear_after_frame got %0d want %0d", n, CLR); end
  endtask

  task automatic test_ready_patterns;
    int n, nb, se, fw, cy;
    logic [15:0] v;
    for (int f = 0; f < 4; f++) begin
      v = 16'($urandom);
      avg_vol = v;
      collect_frame((f == 0) ? 1 : 2, 0, v, nb, se, fw, cy);
      exp_frames++;
      total++; if (nb != 4) begin bad++; $display("FAIL bp%0d_count got %0d want 4", f, nb); end
      total++; if (se != 0) begin bad++; $display("FAIL bp%0d_stall_stable got %0d errors want 0", f, se); end
      total++; if (fw != WIN + DIV) begin bad++; $display("FAIL bp%0d_latency got %0d want %0d", f, fw, WIN + DIV); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] !== model_byte(v, i)) begin
          bad++; $display("FAIL bp%0d_byte%0d got %h want %h", f, i, got[i], model_byte(v, i));
        end
      end
      total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL bp%0d_frame_cnt got %0d want %0d", f, frame_cnt, exp_frames); end
      run_len(0, n);
      total++; if (n != CLR) begin bad++; $display("FAIL bp%0d_clear got %0d want %0d", f, n, CLR); end
    end
  endtask

  task automatic test_force_latch;
    int n, nb, se, fw, cy, fc;
    logic [15:0] v, va;
    for (int it = 0; it < 2; it++) begin
      fc = (it == 0) ? 3 : int'($urandom_range(0, WIN - 1));
      v  = (it == 0) ? 16'h0001 : 16'($urandom);
      va = (it == 0) ? 16'hFFFF : ~v;
      avg_vol = 16'($urandom);
      repeat (fc) @(negedge clk);
      force_req = 1'b1;
      avg_vol = v;
      @(negedge clk);
      force_req = 1'b0;
      total++; if (busy !== 1'b1 || tx_valid !== 1'b0) begin bad++; $display("FAIL force%0d_settle got busy=%b valid=%b want 1,0", it, busy, tx_valid); end
      collect_frame(0, 1, va, nb, se, fw, cy);
      exp_frames++;
      total++; if (fw != DIV) begin bad++; $display("FAIL force%0d_latency got %0d want %0d", it, fw, DIV); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] !== model_byte(v, i)) begin
          bad++; $display("FAIL force%0d_byte%0d got %h want %h", it, i, got[i], model_byte(v, i));
        end
      end
      total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL force%0d_frame_cnt got %0d want %0d", it, frame_cnt, exp_frames); end
      run_len(0, n);
      total++; if (n != CLR) begin bad++; $display("FAIL force%0d_clear got %0d want %0d", it, n, CLR); end
    end
  endtask

  task automatic test_enable_drop;
    int n, nb, se, fw, cy;
    logic [15:0] v;
    v = 16'($urandom);
    avg_vol = v;
    collect_frame(0, 2, v, nb, se, fw, cy);
    exp_frames++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== model_byte(v, i)) begin
        bad++; $display("FAIL endrop_byte%0d got %h want %h", i, got[i], model_byte(v, i));
      end
    end
    run_len(0, n);
    total++; if (n != CLR) begin bad++; $display("FAIL endrop_clear got %0d want %0d", n, CLR); end
    total++; if (busy !== 1'b0 || feedback_finish !== 1'b0) begin bad++; $display("FAIL idle_outputs got busy=%b ff=%b want 0,0", busy, feedback_finish); end
    repeat (WIN + DIV + 10) @(negedge clk);
    total++; if (tx_valid !== 1'b0 || feedback_finish !== 1'b0) begin bad++; $display("FAIL idle_hold got valid=%b ff=%b want 0,0", tx_valid, feedback_finish); end
    v = 16'($urandom);
    avg_vol = v;
    enable = 1'b1;
    collect_frame(0, 0, v, nb, se, fw, cy);
    exp_frames++;
    total++; if (fw != 1 + WIN + DIV) begin bad++; $display("FAIL idle_restart_latency got %0d want %0d", fw, 1 + WIN + DIV); end
    total++; if (got[3] !== model_byte(v, 3)) begin bad++; $display("FAIL idle_restart_csum got %h want %h", got[3], model_byte(v, 3)); end
    run_len(0, n);
  endtask

  task automatic test_reset_mid;
    int n, nb, se, fw, cy;
    logic [15:0] v;
    v = 16'($urandom);
    avg_vol = v;
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++; if (n >= 100) begin bad++; $display("FAIL midrst_wait got timeout want valid"); end
    @(negedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    total++; if (tx_valid !== 1'b1 || tx_data !== v[7:0]) begin bad++; $display("FAIL midrst_byte2 got %b/%h want 1/%h", tx_valid, tx_data, v[7:0]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", tx_valid); end
    total++; if (feedback_finish !== 1'b1) begin bad++; $display("FAIL midrst_ff got %b want 1", feedback_finish); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
    exp_frames = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    tx_ready = 1'b1;
    v = 16'($urandom);
    avg_vol = v;
    @(negedge clk);
    run_len(0, n);
    total++; if (n != CLR) begin bad++; $display("FAIL midrst_clear got %0d want %0d", n, CLR); end
    collect_frame(0, 0, v, nb, se, fw, cy);
    exp_frames++;
    total++; if (fw != WIN + DIV) begin bad++; $display("FAIL midrst_latency got %0d want %0d", fw, WIN + DIV); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== model_byte(v, i)) begin
        bad++; $display("FAIL midrst_byte%0d got %h want %h", i, got[i], model_byte(v, i));
      end
    end
    total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL midrst_frame_cnt_after got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  initial begin
    test_reset();
    test_ready_patterns();
    test_force_latch();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
